// File: rtl/pred_rf_pkg.sv
// rtl/pred_rf_pkg.sv - shared types and width helpers for the predicate register file
package pred_rf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    // Register address width; never narrower than one bit
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Warp index width; a single-warp build still gets a 1-bit port
    function automatic int warp_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pred_rf_clear_fsm.sv
// rtl/pred_rf_clear_fsm.sv - sequences a whole-warp clear one register per cycle
module pred_rf_clear_fsm
    import pred_rf_pkg::*;
#(
    parameter int NUM_WARPS = 8,
    parameter int NUM_REGS  = 64,
    localparam int AW = addr_width(NUM_REGS),
    localparam int WW = warp_width(NUM_WARPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    input  logic [WW-1:0] clr_warp,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr,
    output logic [WW-1:0] clr_cw,
    output logic          clr_busy,
    output logic          clr_done
);

    clr_state_t    state;
    clr_state_t    next_state;
    logic [AW-1:0] ptr;
    logic [WW-1:0] cw;
    logic          last_reg;

    assign last_reg = (ptr == AW'(NUM_REGS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Clear pointer and target warp; warp is captured only when a clear is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            cw  <= '0;
        end else if (state == IDLE && clr_req) begin
            ptr <= '0;
            cw  <= clr_warp;
        end else if (state == CLEAR) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Next-state logic; requests arriving outside IDLE are ignored
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clr_req) next_state = CLEAR;
            CLEAR:   if (last_reg) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Moore outputs towards the storage array and the requester
    always_comb begin
        clr_en   = (state == CLEAR);
        clr_busy = (state == CLEAR) || (state == DONE);
        clr_done = (state == DONE);
        clr_addr = ptr;
        clr_cw   = cw;
    end

endmodule

// File: rtl/pred_reg_file_mp.sv
// rtl/pred_reg_file_mp.sv - multi-port per-warp predicate register file with background warp clear
module pred_reg_file_mp
    import pred_rf_pkg::*;
#(
    parameter int NUM_WARPS  = 8,
    parameter int NUM_LANES  = 8,
    parameter int NUM_REGS   = 64,
    parameter int NUM_RPORTS = 2,
    localparam int AW = addr_width(NUM_REGS),
    localparam int WW = warp_width(NUM_WARPS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [WW-1:0]                         rd_warp,
    input  logic [NUM_RPORTS-1:0][NUM_LANES-1:0]  read_en,
    input  logic [NUM_RPORTS-1:0][AW-1:0]         raddr,
    output logic [NUM_RPORTS-1:0][NUM_LANES-1:0]  rdata,
    output logic [NUM_RPORTS-1:0]                 rany,
    output logic [NUM_RPORTS-1:0]                 rall,
    input  logic [WW-1:0]                         wr_warp,
    input  logic [NUM_LANES-1:0]                  write_en,
    input  logic [AW-1:0]                         waddr,
    input  logic [NUM_LANES-1:0]                  wdata,
    output logic                                  wr_stall,
    input  logic                                  clr_req,
    input  logic [WW-1:0]                         clr_warp,
    output logic                                  clr_busy,
    output logic                                  clr_done
);

    logic [NUM_LANES-1:0] mem [NUM_WARPS][NUM_REGS];

    logic          clr_en;
    logic [AW-1:0] clr_addr;
    logic [WW-1:0] clr_cw;
    logic          wr_fire;
    logic          clr_fire;

    pred_rf_clear_fsm #(
        .NUM_WARPS (NUM_WARPS),
        .NUM_REGS  (NUM_REGS)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_warp (clr_warp),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .clr_cw   (clr_cw),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    // A write into the warp being cleared would race the sweep, so it is refused whole
    assign wr_stall = clr_busy && (wr_warp == clr_cw) && (|write_en);

    assign wr_fire  = (|write_en) && !wr_stall
                    && (32'(waddr) < NUM_REGS) && (32'(wr_warp) < NUM_WARPS);
    assign clr_fire = clr_en && (32'(clr_cw) < NUM_WARPS);

    // Storage: clear sweep and lane-masked write; the stall keeps them off the same warp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    mem[w][r] <= '0;
                end
            end
        end else begin
            if (clr_fire) begin
                mem[clr_cw][clr_addr] <= '0;
            end
            if (wr_fire) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (write_en[l]) begin
                        mem[wr_warp][waddr][l] <= wdata[l];
                    end
                end
            end
        end
    end

    // Zero-latency read with write-through of enabled lanes, then masked by read_en
    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            rdata[p] = '0;
            if ((32'(raddr[p]) < NUM_REGS) && (32'(rd_warp) < NUM_WARPS)) begin
                rdata[p] = mem[rd_warp][raddr[p]];
            end
            if (wr_fire && (wr_warp == rd_warp) && (waddr == raddr[p])) begin
                rdata[p] = (rdata[p] & ~write_en) | (wdata & write_en);
            end
            rdata[p] = rdata[p] & read_en[p];
        end
    end

    // Lane reductions; disabled lanes count as 0 for any and as 1 for all
    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            rany[p] = |rdata[p];
            rall[p] = &(rdata[p] | ~read_en[p]);
        end
    end

endmodule

// File: tb/tb_pred_reg_file_mp.sv
// tb/tb_pred_reg_file_mp.sv - self-checking bench for pred_reg_file_mp
module tb_pred_reg_file_mp;

    localparam int NW = 8;
    localparam int NL = 8;
    localparam int NR = 64;
    localparam int NP = 2;
    localparam int AW = 6;
    localparam int WW = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [WW-1:0]          rd_warp;
    logic [NP-1:0][NL-1:0]  read_en;
    logic [NP-1:0][AW-1:0]  raddr;
    logic [NP-1:0][NL-1:0]  rdata;
    logic [NP-1:0]          rany;
    logic [NP-1:0]          rall;
    logic [WW-1:0]          wr_warp;
    logic [NL-1:0]          write_en;
    logic [AW-1:0]          waddr;
    logic [NL-1:0]          wdata;
    logic                   wr_stall;
    logic                   clr_req;
    logic [WW-1:0]          clr_warp;
    logic                   clr_busy;
    logic                   clr_done;

    int checks   = 0;
    int failures = 0;

    logic [NL-1:0] ref_mem [NW][NR];

    always #5 clk = ~clk;

    pred_reg_file_mp #(
        .NUM_WARPS  (NW),
        .NUM_LANES  (NL),
        .NUM_REGS   (NR),
        .NUM_RPORTS (NP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_warp  (rd_warp),
        .read_en  (read_en),
        .raddr    (raddr),
        .rdata    (rdata),
        .rany     (rany),
        .rall     (rall),
        .wr_warp  (wr_warp),
        .write_en (write_en),
        .waddr    (waddr),
        .wdata    (wdata),
        .wr_stall (wr_stall),
        .clr_req  (clr_req),
        .clr_warp (clr_warp),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected port value from the array model, including same-cycle write-through
    function automatic logic [NL-1:0] exp_read(input int p);
        logic [NL-1:0] v;
        v = ref_mem[rd_warp][raddr[p]];
        if ((write_en != '0) && (wr_warp == rd_warp) && (waddr == raddr[p]))
            v = (v & ~write_en) | (wdata & write_en);
        return v & read_en[p];
    endfunction

    task automatic chk_port(input string tag, input int p, input logic [NL-1:0] exp);
        chk($sformatf("%s_rdata%0d", tag, p), 32'(rdata[p]), 32'(exp));
        chk($sformatf("%s_rany%0d", tag, p), 32'(rany[p]), 32'(|exp));
        chk($sformatf("%s_rall%0d", tag, p), 32'(rall[p]), 32'(&(exp | ~read_en[p])));
    endtask

    task automatic model_write();
        for (int l = 0; l < NL; l++)
            if (write_en[l]) ref_mem[wr_warp][waddr][l] = wdata[l];
    endtask

    initial begin
        bit            saw_done;
        logic [NL-1:0] w1_data;

        rst_n    = 1'b0;
        rd_warp  = '0;
        read_en  = '0;
        raddr    = '0;
        wr_warp  = '0;
        write_en = '0;
        waddr    = '0;
        wdata    = '0;
        clr_req  = 1'b0;
        clr_warp = '0;
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++)
                ref_mem[w][r] = '0;

        // Reset state
        #2;
        chk("rst_busy", 32'(clr_busy), 0);
        chk("rst_done", 32'(clr_done), 0);
        chk("rst_stall", 32'(wr_stall), 0);
        rd_warp    = WW'($urandom_range(0, NW - 1));
        raddr[0]   = AW'($urandom_range(0, NR - 1));
        raddr[1]   = AW'($urandom_range(0, NR - 1));
        read_en[0] = 8'hFF;
        read_en[1] = 8'hFF;
        #1;
        chk_port("rst", 0, 8'h00);
        chk_port("rst", 1, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Partial lane write, then reads with complementary lane masks
        wr_warp = 3; waddr = 10; write_en = 8'h0F; wdata = 8'hA5;
        tick();
        model_write();
        write_en = '0;
        rd_warp = 3; raddr[0] = 10; raddr[1] = 10;
        read_en[0] = 8'hFF; read_en[1] = 8'hF0;
        #1;
        chk("lanes_rdata0", 32'(rdata[0]), 32'h05);
        chk("lanes_rany0", 32'(rany[0]), 1);
        chk("lanes_rall0", 32'(rall[0]), 0);
        chk("lanes_rdata1", 32'(rdata[1]), 32'h00);
        chk("lanes_rany1", 32'(rany[1]), 0);
        chk("lanes_rall1", 32'(rall[1]), 0);

        // Write-through: read the register being written before the edge
        wr_warp = 2; waddr = 7; write_en = 8'hFF; wdata = 8'h3C;
        rd_warp = 2; raddr[0] = 7; read_en[0] = 8'hFF; read_en[1] = 8'h00;
        #1;
        chk("bypass_rdata0", 32'(rdata[0]), 32'h3C);
        chk("noen_rany1", 32'(rany[1]), 0);
        chk("noen_rall1", 32'(rall[1]), 1);
        tick();
        model_write();
        write_en = '0;
        #1;
        chk("bypass_after_edge", 32'(rdata[0]), 32'h3C);

        // Fill every register of every warp, reading back on each port and both
        for (int w = 0; w < NW; w++) begin
            for (int r = 0; r < NR; r++) begin
                wr_warp = WW'(w); waddr = AW'(r); write_en = 8'hFF; wdata = 8'hFF;
                tick();
                model_write();
                write_en = '0;
                rd_warp = WW'(w); raddr[0] = AW'(r); raddr[1] = AW'(r);
                read_en[0] = 8'hFF; read_en[1] = 8'h00;
                #1;
                chk_port("fill_p0", 0, 8'hFF);
                chk_port("fill_p0_off", 1, 8'h00);
                read_en[0] = 8'h00; read_en[1] = 8'hFF;
                #1;
                chk_port("fill_p1", 1, 8'hFF);
                read_en[0] = 8'hFF;
                #1;
                chk_port("fill_both", 0, 8'hFF);
                chk_port("fill_both", 1, 8'hFF);
            end
        end

        // Random writes and reads against the array model
        for (int i = 0; i < 400; i++) begin
            wr_warp    = WW'($urandom_range(0, NW - 1));
            waddr      = AW'($urandom_range(0, NR - 1));
            write_en   = NL'($urandom);
            wdata      = NL'($urandom);
            rd_warp    = ($urandom_range(0, 2) == 0) ? wr_warp : WW'($urandom_range(0, NW - 1));
            raddr[0]   = ($urandom_range(0, 1) == 0) ? waddr : AW'($urandom_range(0, NR - 1));
            raddr[1]   = AW'($urandom_range(0, NR - 1));
            read_en[0] = NL'($urandom);
            read_en[1] = NL'($urandom);
            #1;
            chk_port("rand", 0, exp_read(0));
            chk_port("rand", 1, exp_read(1));
            tick();
            model_write();
        end
        write_en = '0;

        // Refill warp 5 with ones ahead of the clear
        for (int r = 0; r < NR; r++) begin
            wr_warp = 5; waddr = AW'(r); write_en = 8'hFF; wdata = 8'hFF;
            tick();
            model_write();
        end
        write_en = '0;

        // Clear request together with a write to the same warp: write lands, then gets cleared
        clr_warp = 5; clr_req = 1'b1;
        wr_warp = 5; waddr = 3; write_en = 8'hFF; wdata = 8'h11;
        #1;
        chk("clr_start_stall", 32'(wr_stall), 0);
        tick();
        clr_req = 1'b0;
        write_en = '0;

        w1_data = NL'($urandom_range(1, 255));
        for (int n = 1; n <= 70; n++) begin
            write_en = '0;
            clr_req  = 1'b0;
            if (n == 10) begin
                wr_warp = 5; waddr = 0; write_en = 8'hFF; wdata = 8'hFF;
                rd_warp = 5; raddr[0] = 0; raddr[1] = 63;
                read_en[0] = 8'hFF; read_en[1] = 8'hFF;
                #1;
                chk("clr_stall_w5", 32'(wr_stall), 1);
                chk("clr_read_cleared", 32'(rdata[0]), 32'h00);
                chk("clr_read_pending", 32'(rdata[1]), 32'hFF);
            end
            if (n == 12) begin
                wr_warp = 1; waddr = 12; write_en = 8'hFF; wdata = w1_data;
                #1;
                chk("clr_stall_w1", 32'(wr_stall), 0);
                model_write();
            end
            if (n == 15) begin
                clr_req = 1'b1; clr_warp = 4;
            end
            if (n == 65) begin
                wr_warp = 5; waddr = 40; write_en = 8'h0F; wdata = 8'h0F;
                #1;
                chk("done_stall_w5", 32'(wr_stall), 1);
            end
            #1;
            chk($sformatf("clr_busy_c%0d", n), 32'(clr_busy), 32'(n <= 65));
            chk($sformatf("clr_done_c%0d", n), 32'(clr_done), 32'(n == 65));
            tick();
        end
        write_en = '0;
        clr_req  = 1'b0;
        for (int r = 0; r < NR; r++)
            ref_mem[5][r] = '0;

        // Post-clear contents: warp 5 zero, warp 4 untouched, warp 1 write kept
        read_en[0] = 8'hFF; read_en[1] = 8'hFF;
        for (int r = 0; r < NR; r++) begin
            raddr[0] = AW'(r); raddr[1] = AW'(r);
            rd_warp = 5;
            #1;
            chk($sformatf("w5_r%0d", r), 32'(rdata[0]), 32'(ref_mem[5][r]));
            rd_warp = 4;
            #1;
            chk($sformatf("w4_r%0d", r), 32'(rdata[1]), 32'(ref_mem[4][r]));
        end
        rd_warp = 1; raddr[0] = 12;
        #1;
        chk("w1_r12", 32'(rdata[0]), 32'(w1_data));

        // Reset in the middle of a clear
        clr_warp = 6; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        saw_done = 1'b0;
        for (int n = 1; n < 20; n++) begin
            if (clr_done) saw_done = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(clr_busy), 0);
        chk("abort_done", 32'(clr_done), 0);
        chk("abort_stall", 32'(wr_stall), 0);
        for (int n = 0; n < 3; n++) begin
            if (clr_done) saw_done = 1'b1;
            tick();
        end
        rst_n = 1'b1;
        for (int n = 0; n < 80; n++) begin
            if (clr_done) saw_done = 1'b1;
            if (clr_busy) saw_done = 1'b1;
            tick();
        end
        chk("abort_no_done", 32'(saw_done), 0);
        for (int w = 0; w < NW; w++)
            for (int r = 0; r < NR; r++)
                ref_mem[w][r] = '0;
        for (int w = 0; w < NW; w++) begin
            for (int r = 0; r < NR; r++) begin
                rd_warp = WW'(w); raddr[0] = AW'(r); raddr[1] = AW'(r);
                #1;
                chk($sformatf("post_rst_w%0d_r%0d_p0", w, r), 32'(rdata[0]), 32'(ref_mem[w][r]));
                chk($sformatf("post_rst_w%0d_r%0d_p1", w, r), 32'(rdata[1]), 32'(ref_mem[w][r]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pred_reg_file_mp.md
PRED_REG_FILE_MP -- requirements
Module: pred_reg_file_mp

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 8, number of warp contexts.
REQ-002 SHALL have parameter NUM_LANES, default 8, number of SIMD lanes, with one 1-bit predicate per lane.
REQ-003 SHALL have parameter NUM_REGS, default 64, predicate registers per warp.
REQ-004 SHALL have parameter NUM_RPORTS, default 2, number of read ports.
REQ-005 SHALL use the following derived widths: AW=$clog2(NUM_REGS) and WW=max(1,$clog2(NUM_WARPS)).
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clk, input, width 1, rising-edge clock.
REQ-008 SHALL have port rst_n, input, width 1, asynchronous active-low reset.
REQ-009 SHALL have port rd_warp, input, width WW, warp selected for all read ports.
REQ-010 SHALL have port read_en, input, [NUM_RPORTS][NUM_LANES], per-port, per-lane read enable.
REQ-011 SHALL have port raddr, input, [NUM_RPORTS][AW], per-port register address.
REQ-012 SHALL have port rdata, output, [NUM_RPORTS][NUM_LANES], per-port, per-lane predicate.
REQ-013 SHALL have port rany, output, [NUM_RPORTS], OR of the enabled lanes of rdata.
REQ-014 SHALL have port rall, output, [NUM_RPORTS], AND of the enabled lanes of rdata.
REQ-015 SHALL have port wr_warp, input, width WW, write warp, independent of rd_warp.
REQ-016 SHALL have port write_en, input, width NUM_LANES, per-lane write enable.
REQ-017 SHALL have port waddr, input, width AW, write register address.
REQ-018 SHALL have port wdata, input, width NUM_LANES, per-lane write data.
REQ-019 SHALL have port wr_stall, output, width 1, meaning the write this cycle is dropped.
REQ-020 SHALL have port clr_req, input, width 1, single-cycle request to clear a warp.
REQ-021 SHALL have port clr_warp, input, width WW, warp to clear, sampled together with clr_req.
REQ-022 SHALL have port clr_busy, output, width 1, high while a clear is in progress.
REQ-023 SHALL have port clr_done, output, width 1, one-cycle pulse when a clear completes.

Function
REQ-024 Read path SHALL be combinational with zero latency: rdata[p][l] = read_en[p][l] ? mem[rd_warp][raddr[p]][l] : 0.
REQ-025 A write SHALL update mem[wr_warp][waddr][l] = wdata[l] for each l with write_en[l]=1 at the rising edge; lanes with write_en[l]=0 SHALL be unchanged.
REQ-026 A same-cycle write to the same warp, address and enabled lane SHALL be bypassed to rdata (write-through).
REQ-027 rany[p] SHALL equal 0 and rall[p] SHALL equal 1 when read_en[p] is all zero.
REQ-028 raddr or waddr values >= NUM_REGS SHALL read as 0 and SHALL write nothing.
REQ-029 Clear FSM states: IDLE, CLEAR, DONE.
REQ-030 IDLE -> CLEAR on clr_req; the FSM SHALL latch clr_warp and set ptr=0.
REQ-031 In CLEAR, each cycle SHALL zero all lanes of mem[cw][ptr] and increment ptr; when ptr=NUM_REGS-1 the FSM SHALL go to DONE.
REQ-032 DONE SHALL assert clr_done for one cycle, then return to IDLE.
REQ-033 A clear SHALL take exactly NUM_REGS+1 cycles from the clr_req edge to the clr_done pulse.
REQ-034 clr_busy SHALL be high in CLEAR and DONE.
REQ-035 clr_req SHALL be ignored while clr_busy=1.
REQ-036 wr_stall SHALL equal clr_busy && (wr_warp==cw) && |write_en; a stalled write SHALL be dropped entirely.
REQ-037 Writes to other warps SHALL proceed normally during a clear.
REQ-038 Reads of warp cw during a clear SHALL return the current stored contents: already-cleared registers read 0, the rest keep old values.
REQ-039 When clr_req and a write to clr_warp occur in the same cycle, the write SHALL complete, and the clear SHALL then zero that register.

Reset
REQ-040 With rst_n=0, all mem bits SHALL be 0, the FSM SHALL be in IDLE, and ptr, cw, clr_busy, clr_done and wr_stall SHALL be 0, all asynchronously.
REQ-041 Reset asserted mid-clear SHALL abort the clear with no clr_done pulse.

Structure
REQ-042 Package pred_rf_pkg SHALL hold the clear-state enum (IDLE/CLEAR/DONE) and the width helper functions.
REQ-043 Sub-module pred_rf_clear_fsm SHALL hold the FSM, ptr and cw, and SHALL output clear-enable, clear-address and clear-warp to the storage array.

Verification
REQ-044 Bench SHALL, for every warp 0..7 and register 0..63, write write_en=0xFF, wdata=0xFF, then read on port 0, port 1 and both -> rdata=0xFF, rany=1, rall=1.
REQ-045 Bench SHALL write wdata=0xA5 with write_en=0x0F to w3/r10, then read with read_en=0xFF -> rdata=0x05; reading with read_en=0xF0 -> rdata=0x00, rany=0, rall=0.
REQ-046 Bench SHALL write 0x3C to w2/r7 with port 0 reading w2/r7 in the same cycle -> rdata[0]=0x3C before the edge.
REQ-047 Bench SHALL fill w5 with 0xFF and pulse clr_req with clr_warp=5 -> clr_busy for 65 cycles, clr_done on cycle 65, all w5 registers read 0x00, w4 unchanged.
REQ-048 Bench SHALL, during a w5 clear, write to w5 -> wr_stall=1 and data dropped; write to w1 -> wr_stall=0 and data stored; a second clr_req -> ignored.
REQ-049 Bench SHALL drop rst_n at clear cycle 20 -> clr_busy=0, clr_done never pulses, all mem reads 0.
